// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I fetch front end: datapath width, reset vector,
// instruction size and the fixed priority order of PC redirect sources.
package rv32i_pkg;

  localparam int unsigned XLEN        = 32;
  localparam logic [31:0] RESET_VEC   = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES = 4;

  // Redirect source indices; lower index wins arbitration
  localparam int unsigned SRC_TRAP   = 0;
  localparam int unsigned SRC_BRANCH = 1;
  localparam int unsigned SRC_JALR   = 2;
  localparam int unsigned SRC_JAL    = 3;
  localparam int unsigned NSRC       = 4;

  // Index width that stays legal for a single source
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32i_pc_gen_if.sv
// Fetch-side bus of the next-PC generator: redirect requests and stall in,
// fetch PC, flush window and misalignment report out.
interface rv32i_pc_gen_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NSRC = 4
);

  logic                 stall;
  logic [NSRC-1:0]      redir_valid;
  logic [NSRC*XLEN-1:0] redir_target;
  logic [XLEN-1:0]      pc;
  logic                 pc_valid;
  logic                 flush;
  logic                 pending;
  logic                 misalign;
  logic [XLEN-1:0]      misalign_addr;

  modport master (
    output stall, redir_valid, redir_target,
    input  pc, pc_valid, flush, pending, misalign, misalign_addr
  );

  modport slave (
    input  stall, redir_valid, redir_target,
    output pc, pc_valid, flush, pending, misalign, misalign_addr
  );

endinterface

// File: rtl/rv32i_prio_arb.sv
// Fixed-priority redirect arbiter: lowest requesting index wins, and its target
// is selected from the flat per-source target bus.
module rv32i_prio_arb
  import rv32i_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned XLEN = 32,
  parameter int unsigned IDXW = idx_w(NSRC)
) (
  input  logic [NSRC-1:0]      req,
  input  logic [NSRC*XLEN-1:0] tgt_flat,
  output logic                 any,
  output logic [IDXW-1:0]      idx,
  output logic [XLEN-1:0]      tgt
);

  logic [NSRC-1:0][XLEN-1:0] tgt_src;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign tgt_src[i] = tgt_flat[i*XLEN +: XLEN];
  end

  // Scan high to low so the lowest requesting index is the last write
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDXW'(i);
      end
    end
  end

  assign tgt = tgt_src[idx];

endmodule

// File: rtl/rv32i_pc_gen.sv
// Registered next-PC unit: owns the fetch PC, arbitrates redirects, holds one
// redirect across stalls, opens a flush window and reports misaligned targets.
module rv32i_pc_gen
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN       = rv32i_pkg::XLEN,
  parameter int unsigned NSRC       = rv32i_pkg::NSRC,
  parameter logic [XLEN-1:0] RESET_VEC = rv32i_pkg::RESET_VEC,
  parameter int unsigned FLUSH_CYC  = 2,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  rv32i_pc_gen_if.slave  bus
);

  localparam int unsigned IDXW = idx_w(NSRC);
  localparam int unsigned CNTW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  typedef struct packed {
    logic            vld;
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] tgt;
  } redir_t;

  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic [CNTW-1:0] flush_cnt;
  redir_t          pend_q;
  logic            mis_q;
  logic [XLEN-1:0] mis_addr_q;

  logic            arb_any;
  logic [IDXW-1:0] arb_idx;
  logic [XLEN-1:0] arb_tgt;
  redir_t          new_r;
  redir_t          cand;
  logic            use_new;
  logic            cand_mis;

  rv32i_prio_arb #(.NSRC(NSRC), .XLEN(XLEN), .IDXW(IDXW)) u_arb (
    .req      (bus.redir_valid),
    .tgt_flat (bus.redir_target),
    .any      (arb_any),
    .idx      (arb_idx),
    .tgt      (arb_tgt)
  );

  // A fresh request beats the held one only at equal or higher priority
  always_comb begin
    new_r     = '0;
    new_r.vld = arb_any & pc_valid_q;
    new_r.idx = arb_idx;
    new_r.tgt = arb_tgt;
    use_new   = new_r.vld && (!pend_q.vld || (new_r.idx <= pend_q.idx));
    cand      = use_new ? new_r : pend_q;
    cand_mis  = cand.vld && ((cand.tgt & ALIGN_MASK) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      flush_cnt  <= '0;
      pend_q     <= '0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      pc_valid_q <= 1'b1;
      mis_q      <= 1'b0;
      // Flush window only ages while fetch is moving
      if (!bus.stall && (flush_cnt != '0))
        flush_cnt <= flush_cnt - CNTW'(1);
      if (pc_valid_q) begin
        if (cand_mis) begin
          mis_q      <= 1'b1;
          mis_addr_q <= cand.tgt;
          if (!use_new)
            pend_q.vld <= 1'b0;
        end else if (bus.stall) begin
          if (new_r.vld)
            pend_q <= cand;
        end else if (cand.vld) begin
          pc_q       <= cand.tgt;
          pend_q.vld <= 1'b0;
          flush_cnt  <= CNTW'(FLUSH_CYC);
        end else begin
          pc_q <= pc_q + XLEN'(INSTR_BYTES);
        end
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.flush         = (flush_cnt != '0);
  assign bus.pending       = pend_q.vld;
  assign bus.misalign      = mis_q;
  assign bus.misalign_addr = mis_addr_q;

endmodule

// File: tb/tb_rv32i_pc_gen.sv
// Directed bench for rv32i_pc_gen: a per-cycle vector table plus hand sequences
// for reset-with-pending and redirects during the post-reset cycle.
module tb_rv32i_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_pc_gen_if #(.XLEN(32), .NSRC(4)) bus ();

  rv32i_pc_gen #(
    .XLEN(32), .NSRC(4), .RESET_VEC(RV), .FLUSH_CYC(2), .ALIGN_BITS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        stall;
    logic [3:0]  rv;
    logic [31:0] t0, t1, t2, t3;
    logic [31:0] pc;
    logic        fl, pd, ms;
    logic [31:0] ma;
  } vec_t;

  vec_t vq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic add(input logic st, input logic [3:0] rv,
                     input logic [31:0] t0, t1, t2, t3, pc,
                     input logic fl, pd, ms, input logic [31:0] ma);
    vec_t v;
    v.stall = st; v.rv = rv; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
    v.pc = pc; v.fl = fl; v.pd = pd; v.ms = ms; v.ma = ma;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [3:0] rv,
                       input logic [31:0] t0, t1, t2, t3);
    bus.stall        = st;
    bus.redir_valid  = rv;
    bus.redir_target = {t3, t2, t1, t0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic pv,
                         input logic fl, pd, ms);
    chk({tag, ".pc"},       bus.pc,       pc);
    chk({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(pv));
    chk({tag, ".flush"},    32'(bus.flush),    32'(fl));
    chk({tag, ".pending"},  32'(bus.pending),  32'(pd));
    chk({tag, ".misalign"}, 32'(bus.misalign), 32'(ms));
  endtask

  initial begin
    // st rv      t0            t1            t2           t3           pc            fl pd ms ma
    // normal sequential fetch after reset
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h100, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h104, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h108, 0, 0, 0, 0);
    // two sources at once: branch beats jalr, two-cycle flush
    add(0, 4'b0110, 0, 32'h200, 32'h300, 0,                            32'h200, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h204, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h208, 0, 0, 0, 0);
    // misaligned trap target: pc holds that edge, no flush
    add(0, 4'b0001, 32'h1002, 0, 0, 0,                                 32'h208, 0, 0, 1, 32'h1002);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h20c, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h210, 0, 0, 0, 0);
    // all four request, then reload during active window
    add(0, 4'b1111, 32'h700, 32'h710, 32'h720, 32'h730,                32'h700, 1, 0, 0, 0);
    add(0, 4'b1000, 0, 0, 0, 32'h800,                                  32'h800, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h804, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h808, 0, 0, 0, 0);
    // stall stretches the flush window
    add(0, 4'b0100, 0, 0, 32'h900, 0,                                  32'h900, 1, 0, 0, 0);
    add(1, 4'b0000, 0, 0, 0, 0,                                        32'h900, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h904, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h908, 0, 0, 0, 0);
    // redirects under stall: jal, then branch replaces, jalr loses
    add(1, 4'b1000, 0, 0, 0, 32'h400,                                  32'h908, 0, 1, 0, 0);
    add(1, 4'b0000, 0, 0, 0, 0,                                        32'h908, 0, 1, 0, 0);
    add(1, 4'b0010, 0, 32'h500, 0, 0,                                  32'h908, 0, 1, 0, 0);
    add(1, 4'b0100, 0, 0, 32'h600, 0,                                  32'h908, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h500, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h504, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h508, 0, 0, 0, 0);
    // misaligned new request under stall, with and without a held redirect
    add(1, 4'b0010, 0, 32'hb02, 0, 0,                                  32'h508, 0, 0, 1, 32'hb02);
    add(1, 4'b0100, 0, 0, 32'hc00, 0,                                  32'h508, 0, 1, 0, 0);
    add(1, 4'b0001, 32'hd01, 0, 0, 0,                                  32'h508, 0, 1, 1, 32'hd01);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'hc00, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'hc04, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'hc08, 0, 0, 0, 0);
    // wrap at the top of the address space
    add(0, 4'b0010, 0, 32'hffff_fff8, 0, 0,                            32'hffff_fff8, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'hffff_fffc, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0,                                        32'h4, 0, 0, 0, 0);

    rst = 1'b1;
    drive(0, 4'b0000, 0, 0, 0, 0);
    tick();
    tick();
    chk_all("reset", RV, 0, 0, 0, 0);
    chk("reset.misalign_addr", bus.misalign_addr, 32'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vq[i].stall, vq[i].rv, vq[i].t0, vq[i].t1, vq[i].t2, vq[i].t3);
      tick();
      chk_all(tag, vq[i].pc, 1, vq[i].fl, vq[i].pd, vq[i].ms);
      if (vq[i].ms)
        chk({tag, ".misalign_addr"}, bus.misalign_addr, vq[i].ma);
    end

    // reset while a redirect is held and a flush window is open
    drive(0, 4'b0001, 32'h3000, 0, 0, 0);
    tick();
    chk_all("rp.redir", 32'h3000, 1, 1, 0, 0);
    drive(1, 4'b1000, 0, 0, 0, 32'h4000);
    tick();
    chk_all("rp.hold", 32'h3000, 1, 1, 1, 0);
    rst = 1'b1;
    drive(1, 4'b0000, 0, 0, 0, 0);
    tick();
    chk_all("rp.reset", RV, 0, 0, 0, 0);
    rst = 1'b0;
    // redirect in the pc_valid=0 cycle must be ignored
    drive(0, 4'b0001, 32'h5000, 0, 0, 0);
    tick();
    chk_all("rp.first", RV, 1, 0, 0, 0);
    drive(0, 4'b0000, 0, 0, 0, 0);
    tick();
    chk_all("rp.seq1", RV + 32'h4, 1, 0, 0, 0);
    tick();
    chk_all("rp.seq2", RV + 32'h8, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
